// File: rtl/s2p.sv
// s2p: serial-to-parallel converter. Collects N serial bits (LSB first)
// into a word and presents it through a one-word valid/ready holding
// register; assembly of the next word continues while a word is pending.
//
// Ports:
//   clk      in   clock, rising edge
//   rstn     in   asynchronous active-low reset
//   s_valid  in   serial bit valid
//   s_data   in   serial data bit
//   s_ready  out  a serial bit can be accepted this cycle (from state only)
//   flush    in   synchronous discard of the partial word
//   p_valid  out  holding register contains a complete word
//   p_data   out  assembled word, bit k = k-th serial bit
//   p_ready  in   consumer accepts the word this cycle
//   bit_cnt  out  bits of the current partial word already accepted
module s2p #(
    parameter int unsigned N = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 s_valid,
    input  logic                 s_data,
    output logic                 s_ready,
    input  logic                 flush,
    output logic                 p_valid,
    output logic [N-1:0]         p_data,
    input  logic                 p_ready,
    output logic [$clog2(N)-1:0] bit_cnt
);

    localparam int unsigned CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [N-1:0]  r_shreg;
    logic [CW-1:0] r_cnt;
    logic [N-1:0]  r_p_data;
    logic          r_p_valid;

    logic          w_last;
    logic          w_ready;
    logic          w_xfer;
    logic          w_done;
    logic [N-1:0]  w_shreg_nxt;

    // Stall only when the final bit would complete a word the holding
    // register cannot take; depends on registered state alone.
    assign w_last  = (r_cnt == LAST);
    assign w_ready = !(w_last && r_p_valid);
    assign w_xfer  = s_valid && w_ready && !flush;
    assign w_done  = w_xfer && w_last;

    // Assembly register with the incoming bit dropped into slot cnt; on
    // completion (cnt == N-1) this is exactly {s_data, shreg[N-2:0]}.
    always_comb begin
        w_shreg_nxt        = r_shreg;
        w_shreg_nxt[r_cnt] = s_data;
    end

    // Assembly path: counter and shift register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_cnt <= '0;
        end else if (w_xfer) begin
            r_shreg <= w_shreg_nxt;
            r_cnt   <= w_last ? '0 : r_cnt + CW'(1);
        end
    end

    // Holding register; a completion takes priority over the handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_p_data  <= '0;
            r_p_valid <= 1'b0;
        end else if (w_done) begin
            r_p_data  <= w_shreg_nxt;
            r_p_valid <= 1'b1;
        end else if (r_p_valid && p_ready) begin
            r_p_valid <= 1'b0;
        end
    end

    assign s_ready = w_ready;
    assign p_valid = r_p_valid;
    assign p_data  = r_p_data;
    assign bit_cnt = r_cnt;

endmodule

// File: tb/tb_s2p.sv
// tb_s2p: directed self-checking bench for s2p with N=8.
module tb_s2p;

    logic       clk;
    logic       rstn;
    logic       s_valid;
    logic       s_data;
    logic       s_ready;
    logic       flush;
    logic       p_valid;
    logic [7:0] p_data;
    logic       p_ready;
    logic [2:0] bit_cnt;

    int errors = 0;
    int checks = 0;

    s2p #(.N(8)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .flush   (flush),
        .p_valid (p_valid),
        .p_data  (p_data),
        .p_ready (p_ready),
        .bit_cnt (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; sample point is 1 ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer the low nbits bits of w, LSB first, one per cycle.
    task automatic send_bits(input logic [7:0] w, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            s_valid = 1'b1;
            s_data  = w[i];
            step();
        end
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; s_valid = 1'b0; s_data = 1'b0; flush = 1'b0; p_ready = 1'b0;
        #12;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_s_ready: got %b want 1", s_ready); end
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL rst_p_valid: got %b want 0", p_valid); end
        checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL rst_p_data: got %h want 00", p_data); end
        checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL rst_bit_cnt: got %0d want 0", bit_cnt); end
        @(negedge clk);
        rstn = 1'b1;
        step();
        // Pending word plus a 3-bit partial, then an asynchronous reset.
        send_bits(8'hFF, 8);
        send_bits(8'h07, 3);
        checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_p_valid: got %b want 1", p_valid); end
        checks++; if (bit_cnt !== 3'd3) begin errors++; $display("FAIL pre_rst_bit_cnt: got %0d want 3", bit_cnt); end
        #2;
        rstn = 1'b0;
        #1;
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL async_rst_p_valid: got %b want 0", p_valid); end
        checks++; if (p_data !== 8'h00) begin errors++; $display("FAIL async_rst_p_data: got %h want 00", p_data); end
        checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL async_rst_bit_cnt: got %0d want 0", bit_cnt); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL async_rst_s_ready: got %b want 1", s_ready); end
        #1;
        rstn = 1'b1;
        p_ready = 1'b1;
        step();
        send_bits(8'h96, 8);
        checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL post_rst_p_valid: got %b want 1", p_valid); end
        checks++; if (p_data !== 8'h96) begin errors++; $display("FAIL post_rst_p_data: got %h want 96", p_data); end
        step();
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL post_rst_drain: got %b want 0", p_valid); end
    endtask

    task automatic test_single();
        p_ready = 1'b1;
        send_bits(8'hA5, 7);
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", p_valid); end
        checks++; if (bit_cnt !== 3'd7) begin errors++; $display("FAIL single_bit_cnt7: got %0d want 7", bit_cnt); end
        s_valid = 1'b1; s_data = 1'b1;
        step();
        s_valid = 1'b0;
        checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL single_p_valid: got %b want 1", p_valid); end
        checks++; if (p_data !== 8'hA5) begin errors++; $display("FAIL single_p_data: got %h want a5", p_data); end
        checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL single_bit_cnt0: got %0d want 0", bit_cnt); end
        step();
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b want 0", p_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] stream;
        int          n_pulse;
        int          n_stall;
        int          pulse_at [2];
        logic [7:0]  pulse_dat [2];
        stream   = 16'hC33C;
        n_pulse  = 0;
        n_stall  = 0;
        pulse_at = '{-1, -1};
        pulse_dat = '{8'h00, 8'h00};
        p_ready  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            s_valid = 1'b1;
            s_data  = stream[i];
            if (s_ready !== 1'b1) n_stall++;
            step();
            if (p_valid === 1'b1) begin
                if (n_pulse < 2) begin
                    pulse_at[n_pulse]  = i;
                    pulse_dat[n_pulse] = p_data;
                end
                n_pulse++;
            end
        end
        s_valid = 1'b0;
        checks++; if (n_stall !== 0) begin errors++; $display("FAIL b2b_stalls: got %0d want 0", n_stall); end
        checks++; if (n_pulse !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", n_pulse); end
        checks++; if (pulse_at[0] !== 7) begin errors++; $display("FAIL b2b_first_at: got %0d want 7", pulse_at[0]); end
        checks++; if (pulse_at[1] !== 15) begin errors++; $display("FAIL b2b_second_at: got %0d want 15", pulse_at[1]); end
        checks++; if (pulse_dat[0] !== 8'h3C) begin errors++; $display("FAIL b2b_first_data: got %h want 3c", pulse_dat[0]); end
        checks++; if (pulse_dat[1] !== 8'hC3) begin errors++; $display("FAIL b2b_second_data: got %h want c3", pulse_dat[1]); end
        step();
    endtask

    task automatic test_backpressure();
        p_ready = 1'b0;
        send_bits(8'h12, 8);
        send_bits(8'h34, 7);
        checks++; if (bit_cnt !== 3'd7) begin errors++; $display("FAIL bp_bit_cnt: got %0d want 7", bit_cnt); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready: got %b want 0", s_ready); end
        // Offer the last bit while stalled; it must not be taken.
        s_valid = 1'b1; s_data = 1'b0;
        step();
        step();
        checks++; if (p_data !== 8'h12) begin errors++; $display("FAIL bp_hold_data: got %h want 12", p_data); end
        checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %b want 1", p_valid); end
        checks++; if (bit_cnt !== 3'd7) begin errors++; $display("FAIL bp_hold_cnt: got %0d want 7", bit_cnt); end
        p_ready = 1'b1;
        step();
        p_ready = 1'b0;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", s_ready); end
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", p_valid); end
        step();
        s_valid = 1'b0;
        checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL bp_final_valid: got %b want 1", p_valid); end
        checks++; if (p_data !== 8'h34) begin errors++; $display("FAIL bp_final_data: got %h want 34", p_data); end
        p_ready = 1'b1;
        step();
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %b want 0", p_valid); end
    endtask

    task automatic test_gapped();
        logic [7:0] w;
        int         gaps [8];
        int         n_word;
        logic [7:0] got;
        w       = 8'h5A;
        gaps    = '{0, 2, 1, 3, 0, 3, 1, 2};
        n_word  = 0;
        got     = 8'h00;
        p_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                s_valid = 1'b0;
                s_data  = 1'($urandom);
                step();
                if (p_valid === 1'b1) begin n_word++; got = p_data; end
            end
            s_valid = 1'b1;
            s_data  = w[i];
            step();
            if (p_valid === 1'b1) begin n_word++; got = p_data; end
        end
        s_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_data = 1'($urandom);
            step();
            if (p_valid === 1'b1) begin n_word++; got = p_data; end
        end
        checks++; if (n_word !== 1) begin errors++; $display("FAIL gap_word_count: got %0d want 1", n_word); end
        checks++; if (got !== 8'h5A) begin errors++; $display("FAIL gap_data: got %h want 5a", got); end
    endtask

    task automatic test_flush();
        p_ready = 1'b0;
        send_bits(8'hE7, 8);
        send_bits(8'h07, 3);
        checks++; if (bit_cnt !== 3'd3) begin errors++; $display("FAIL fl_pre_cnt: got %0d want 3", bit_cnt); end
        flush = 1'b1; s_valid = 1'b1; s_data = 1'b1;
        step();
        flush = 1'b0; s_valid = 1'b0;
        checks++; if (bit_cnt !== 3'd0) begin errors++; $display("FAIL fl_cnt: got %0d want 0", bit_cnt); end
        checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL fl_pending_valid: got %b want 1", p_valid); end
        checks++; if (p_data !== 8'hE7) begin errors++; $display("FAIL fl_pending_data: got %h want e7", p_data); end
        send_bits(8'h81, 7);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL fl_stall: got %b want 0", s_ready); end
        checks++; if (p_data !== 8'hE7) begin errors++; $display("FAIL fl_deliver_data: got %h want e7", p_data); end
        p_ready = 1'b1;
        step();
        p_ready = 1'b0;
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL fl_delivered: got %b want 0", p_valid); end
        s_valid = 1'b1; s_data = 1'b1;
        step();
        s_valid = 1'b0;
        checks++; if (p_valid !== 1'b1) begin errors++; $display("FAIL fl_word_valid: got %b want 1", p_valid); end
        checks++; if (p_data !== 8'h81) begin errors++; $display("FAIL fl_word_data: got %h want 81", p_data); end
        p_ready = 1'b1;
        step();
        checks++; if (p_valid !== 1'b0) begin errors++; $display("FAIL fl_drain: got %b want 0", p_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_gapped();
        test_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
